// File: rtl/nios_system_pulse_out_pkg.sv
// Shared constants and types for the pulse output PIO.
// Register map, control bit positions and timer state encoding.
package nios_system_pulse_out_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_LEN    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_MASK   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_CLRDONE = 2;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;

  typedef enum logic {
    IDLE,
    PULSE
  } state_e;

endpackage

// File: rtl/nios_system_pulse_timer.sv
// One-shot pulse timer: FSM plus down-counter.
// done_pulse is high in the last pulse cycle, aligned with the return to IDLE.
module nios_system_pulse_timer
  import nios_system_pulse_out_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             done_pulse
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = PULSE;
          cnt_d   = (len == '0) ? CNT_W'(1) : len;
        end
      end
      PULSE: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d    = IDLE;
          cnt_d      = '0;
          done_pulse = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy = (state_q == PULSE);

endmodule

// File: rtl/nios_system_pulse_out.sv
// Avalon-MM output PIO with level, set/clear and one-shot masked pulse.
// out_port is an XOR of flops only, so it never glitches.
module nios_system_pulse_out
  import nios_system_pulse_out_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             done_q, done_d;
  logic [31:0]      rd_q, rd_d;

  logic wr, ctrl_wr;
  logic start, abort, clrdone;
  logic busy, done_pulse;
  logic wd_unused;

  assign wr      = chipselect && !write_n;
  assign ctrl_wr = wr && (address == ADDR_CTRL);
  assign start   = ctrl_wr && writedata[CTRL_START];
  assign abort   = ctrl_wr && writedata[CTRL_ABORT];
  assign clrdone = ctrl_wr && writedata[CTRL_CLRDONE];
  assign wd_unused = ^writedata;

  nios_system_pulse_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .len       (len_q),
    .busy      (busy),
    .done_pulse(done_pulse)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      mask_q <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      len_q  <= len_d;
      done_q <= done_d;
      rd_q   <= rd_d;
    end
  end

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    len_d  = len_q;
    done_d = done_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_d = writedata[WIDTH-1:0];
        ADDR_LEN:    len_d  = writedata[CNT_W-1:0];
        ADDR_MASK:   mask_d = writedata[WIDTH-1:0];
        ADDR_OUTSET: data_d = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLR: data_d = data_q & ~writedata[WIDTH-1:0];
        default:     ;
      endcase
    end
    // A DONE set on the final pulse edge beats a same-edge CLRDONE
    if (done_pulse) begin
      done_d = 1'b1;
    end else if (clrdone) begin
      done_d = 1'b0;
    end
  end

  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_DATA: rd_d = 32'(data_q);
      ADDR_LEN:  rd_d = 32'(len_q);
      ADDR_CTRL: begin
        rd_d[STAT_BUSY] = busy;
        rd_d[STAT_DONE] = done_q;
      end
      ADDR_MASK: rd_d = 32'(mask_q);
      default:   rd_d = '0;
    endcase
  end

  assign readdata = rd_q;
  assign out_port = data_q ^ (mask_q & {WIDTH{busy}});

endmodule

// File: tb/tb_nios_system_pulse_out.sv
// Bench for nios_system_pulse_out: directed scenarios plus random traffic
// against a cycle-indexed model of the register file and pulse window.
module tb_nios_system_pulse_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int checks;
  int errors;

  // model state
  int          cyc;
  int          m_end;
  bit          m_busy;
  bit          m_done;
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [15:0] m_len;
  logic [31:0] m_rd;

  nios_system_pulse_out #(
    .WIDTH(8),
    .CNT_W(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] m_out();
    return m_data ^ (m_busy ? m_mask : 8'h00);
  endfunction

  task automatic model_clear();
    m_busy = 0;
    m_done = 0;
    m_data = '0;
    m_mask = '0;
    m_len  = '0;
    m_rd   = '0;
    m_end  = 0;
  endtask

  task automatic model_edge(input logic [2:0] a, input bit cs, input bit wn,
                            input logic [31:0] wd);
    bit w, st, ab, cl, set;
    w  = cs && !wn;
    st = w && a == 3'd2 && wd[0];
    ab = w && a == 3'd2 && wd[1];
    cl = w && a == 3'd2 && wd[2];
    case (a)
      3'd0: m_rd = {24'd0, m_data};
      3'd1: m_rd = {16'd0, m_len};
      3'd2: m_rd = {30'd0, m_done, m_busy};
      3'd3: m_rd = {24'd0, m_mask};
      default: m_rd = 32'd0;
    endcase
    set = 0;
    if (m_busy) begin
      if (ab) m_busy = 0;
      else if (cyc == m_end) begin
        m_busy = 0;
        set = 1;
      end
    end else if (st && !ab) begin
      m_busy = 1;
      m_end  = cyc + ((m_len == 0) ? 1 : int'(m_len));
    end
    if (set) m_done = 1;
    else if (cl) m_done = 0;
    if (w) begin
      case (a)
        3'd0: m_data = wd[7:0];
        3'd1: m_len  = wd[15:0];
        3'd3: m_mask = wd[7:0];
        3'd4: m_data = m_data | wd[7:0];
        3'd5: m_data = m_data & ~wd[7:0];
        default: ;
      endcase
    end
  endtask

  // One clock edge with the given bus inputs; returns #1 after the edge
  task automatic bus(input logic [2:0] a, input bit cs, input bit wn,
                     input logic [31:0] wd);
    @(negedge clk);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    @(posedge clk);
    cyc++;
    model_edge(a, cs, wn, wd);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    bus(a, 1'b1, 1'b0, wd);
  endtask

  task automatic rd(input logic [2:0] a);
    bus(a, 1'b0, 1'b1, 32'hDEAD_BEEF);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (out_port !== 8'h00 || readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: out_port=%h readdata=%h, want 00/0",
               out_port, readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      checks++;
      if (readdata !== 32'd0 || out_port !== 8'h00) begin
        errors++;
        $display("FAIL reset_read a=%0d: rd=%h out=%h, want 0/00",
                 a, readdata, out_port);
      end
    end
  endtask

  task automatic test_data();
    logic [7:0] exp [3];
    exp[0] = 8'hA5;
    exp[1] = 8'hAF;
    exp[2] = 8'h2E;
    wr(3'd0, 32'hFFFF_FFA5);
    checks++;
    if (out_port !== exp[0]) begin
      errors++;
      $display("FAIL data_write: out=%h want %h", out_port, exp[0]);
    end
    wr(3'd4, 32'h0000_000F);
    checks++;
    if (out_port !== exp[1]) begin
      errors++;
      $display("FAIL outset: out=%h want %h", out_port, exp[1]);
    end
    wr(3'd5, 32'h0000_0081);
    checks++;
    if (out_port !== exp[2]) begin
      errors++;
      $display("FAIL outclear: out=%h want %h", out_port, exp[2]);
    end
    rd(3'd0);
    checks++;
    if (readdata !== 32'h2E) begin
      errors++;
      $display("FAIL data_read: rd=%h want 0000002e", readdata);
    end
  endtask

  task automatic test_pulse();
    wr(3'd0, 32'h0);
    wr(3'd3, 32'h3);
    wr(3'd1, 32'd5);
    wr(3'd2, 32'h1);
    checks++;
    if (out_port !== 8'h03) begin
      errors++;
      $display("FAIL pulse_c0: out=%h want 03", out_port);
    end
    for (int i = 1; i < 5; i++) begin
      rd(3'd2);
      checks++;
      if (out_port !== 8'h03 || readdata !== 32'h1) begin
        errors++;
        $display("FAIL pulse_c%0d: out=%h rd=%h want 03/1",
                 i, out_port, readdata);
      end
    end
    rd(3'd2);
    checks++;
    if (out_port !== 8'h00 || readdata !== 32'h1) begin
      errors++;
      $display("FAIL pulse_end: out=%h rd=%h want 00/1", out_port, readdata);
    end
    rd(3'd2);
    checks++;
    if (readdata !== 32'h2) begin
      errors++;
      $display("FAIL pulse_done: rd=%h want 2", readdata);
    end
    wr(3'd2, 32'h4);
    rd(3'd2);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL clrdone: rd=%h want 0", readdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h1);
    checks++;
    if (out_port !== 8'h03) begin
      errors++;
      $display("FAIL len0_on: out=%h want 03", out_port);
    end
    rd(3'd0);
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL len0_off: out=%h want 00", out_port);
    end
    exp[0] = 8'h03;
    exp[1] = 8'h03;
    exp[2] = 8'h03;
    exp[3] = 8'h00;
    wr(3'd1, 32'd3);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) wr(3'd2, 32'h1);
      else rd(3'd0);
      checks++;
      if (out_port !== exp[i]) begin
        errors++;
        $display("FAIL retrigger c%0d: out=%h want %h", i, out_port, exp[i]);
      end
    end
    wr(3'd2, 32'h4);
  endtask

  task automatic test_abort();
    wr(3'd1, 32'd100);
    wr(3'd2, 32'h1);
    for (int i = 1; i < 10; i++) begin
      rd(3'd0);
      checks++;
      if (out_port !== 8'h03) begin
        errors++;
        $display("FAIL abort_run c%0d: out=%h want 03", i, out_port);
      end
    end
    wr(3'd2, 32'h2);
    checks++;
    if (out_port !== 8'h00) begin
      errors++;
      $display("FAIL abort_off: out=%h want 00", out_port);
    end
    rd(3'd2);
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_status: rd=%h want 0", readdata);
    end
    wr(3'd2, 32'h3);
    rd(3'd2);
    checks++;
    if (out_port !== 8'h00 || readdata !== 32'h0) begin
      errors++;
      $display("FAIL start_abort: out=%h rd=%h want 00/0", out_port, readdata);
    end
  endtask

  task automatic test_midpulse();
    wr(3'd1, 32'd20);
    wr(3'd2, 32'h1);
    wr(3'd3, 32'hF0);
    checks++;
    if (out_port !== 8'hF0) begin
      errors++;
      $display("FAIL mid_mask: out=%h want f0", out_port);
    end
    wr(3'd4, 32'h01);
    checks++;
    if (out_port !== 8'hF1) begin
      errors++;
      $display("FAIL mid_outset: out=%h want f1", out_port);
    end
    wr(3'd1, 32'd2);
    for (int i = 4; i < 20; i++) rd(3'd0);
    checks++;
    if (out_port !== 8'hF1) begin
      errors++;
      $display("FAIL mid_len_last: out=%h want f1", out_port);
    end
    rd(3'd0);
    checks++;
    if (out_port !== 8'h01) begin
      errors++;
      $display("FAIL mid_len_end: out=%h want 01", out_port);
    end
    wr(3'd1, 32'd50);
    wr(3'd2, 32'h1);
    rd(3'd0);
    rd(3'd0);
    checks++;
    if (out_port !== 8'hF1) begin
      errors++;
      $display("FAIL reset_pre: out=%h want f1", out_port);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] wd;
    bit          cs, wn;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      if (a == 3'd1) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
      if (a == 3'd2 && $urandom_range(0, 3) != 0) wd = wd & 32'hFFFF_FFF5;
      bus(a, cs, wn, wd);
      checks++;
      if (out_port !== m_out() || readdata !== m_rd) begin
        errors++;
        $display("FAIL random i=%0d: out=%h rd=%h want %h/%h",
                 i, out_port, readdata, m_out(), m_rd);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    reset_n    = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    model_clear();
    test_reset();
    test_data();
    test_pulse();
    test_back_to_back();
    test_abort();
    test_midpulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios_system_pulse_out.md
# nios_system_pulse_out

Avalon-MM slave output port for the Nios II system: the write-side counterpart of the system's read-only input PIOs. Software writes a level register, set/clear masks and a one-shot pulse configuration. The block drives `out_port` from registered state and can invert a masked subset of bits for a programmed number of clock cycles. It sits on the Nios data master's interconnect alongside the input PIOs and drives board-level or fabric control signals.

## Interface
- `WIDTH`, 8, width of `out_port` and of the data/mask registers (1..32)
- `CNT_W`, 16, width of the pulse-length register and down-counter (1..32)

- `clk`  in  1  system clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `address`  in  3  word address of register
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  registered read data
- `out_port`  out  WIDTH  driven port value

## Operation
- A write occurs on any rising edge with `chipselect=1 && write_n=0`. There are no wait states.
- Register map (word addresses):
  - 0 DATA: R/W, `WIDTH` bits; idle level of `out_port`
  - 1 LEN: R/W, `CNT_W` bits; pulse length in cycles; LEN=0 is treated as 1
  - 2 CTRL/STATUS, write:
    - bit0 START: begins a pulse if idle
    - bit1 ABORT: ends the pulse
    - bit2 CLRDONE: clears DONE
  - 2 CTRL/STATUS, read: bit0 BUSY, bit1 DONE, other bits 0
  - 3 MASK: R/W, `WIDTH` bits; bits inverted while BUSY
  - 4 OUTSET, write-only: DATA <= DATA | writedata[WIDTH-1:0]
  - 5 OUTCLEAR, write-only: DATA <= DATA & ~writedata[WIDTH-1:0]
  - 4..7 read as 0. Writes to 6 and 7 are ignored.
- `out_port = DATA ^ (MASK & {WIDTH{BUSY}})`. All terms are flops, so the output is glitch-free.
- FSM has two states, IDLE and PULSE (BUSY = state==PULSE):
  - IDLE -> PULSE on a START write. The counter loads max(LEN,1).
  - In PULSE, the counter decrements each cycle.
  - PULSE -> IDLE when counter==1. DONE is set on that same edge.
  - PULSE -> IDLE on an ABORT write. DONE is not set.
- Boundary rules:
  - START while PULSE: ignored; no retrigger, counter not reloaded.
  - START and ABORT in the same write: ABORT wins. The state stays or becomes IDLE.
  - CLRDONE on the same edge that DONE is set: set wins.
  - LEN or MASK written during PULSE: a LEN write affects only the next pulse. A MASK write takes effect on `out_port` immediately.
  - DATA/OUTSET/OUTCLEAR during PULSE: update DATA immediately; the mask XOR still applies.
  - `reset_n` asserted mid-pulse: immediate return to IDLE, all registers cleared.
- Unused high bits of `writedata` are discarded. Reads zero-extend.

## Timing
- Reset values (asynchronous): DATA=0, LEN=0, MASK=0, state IDLE, counter=0, DONE=0, `readdata`=0, `out_port`=0.
- Read latency is 1 cycle: `readdata` registers the mux of `address` on every rising edge, independent of `chipselect`.
- Register writes are visible on `out_port` in the cycle after the write edge.
- For a START at edge k: BUSY=1 and the inverted bits appear after edge k. They revert after edge k+N (N=max(LEN,1)), so the pulse is exactly N cycles wide. DONE=1 and BUSY=0 from edge k+N.
- An ABORT at edge j during a pulse drops BUSY after edge j.
- A read of STATUS issued at edge m returns the state as of before edge m.

## Structure
- Shared package `nios_system_pulse_out_pkg` holds:
  - address constants: ADDR_DATA=0, ADDR_LEN=1, ADDR_CTRL=2, ADDR_MASK=3, ADDR_OUTSET=4, ADDR_OUTCLR=5
  - CTRL bit positions: START=0, ABORT=1, CLRDONE=2, BUSY=0, DONE=1
  - the state enum {IDLE, PULSE}
- Sub-module `nios_system_pulse_timer` (parameter `CNT_W`):
  - inputs: `start`, `abort`, `len`
  - outputs: `busy`, `done_pulse`
  - contains the FSM and down-counter
- The top level holds the register file, read mux and output XOR.

## Test plan
- Reset, then read addresses 0..7: all reads 0, `out_port`=0x00. Assert `reset_n` mid-pulse: `out_port` returns to 0 asynchronously.
- DATA=0xA5; OUTSET 0x0F; OUTCLEAR 0x81 -> `out_port` 0xA5, then 0xAF, then 0x2E. A read of addr 0 returns 0x2E one cycle after address.
- DATA=0x00, MASK=0x03, LEN=5, START -> `out_port`=0x03 for exactly 5 cycles, then 0x00. STATUS reads 0x1 during the pulse and 0x2 after; CLRDONE gives 0x0.
- LEN=0, START -> 1-cycle pulse. LEN=3, START, then START again in cycle 2 -> a single 3-cycle pulse, no extension.
- LEN=100, START, ABORT at cycle 10 -> the pulse ends after 10 cycles and DONE stays 0. A write of 0x3 (START+ABORT) while idle -> no pulse.
- During a LEN=20 pulse, write MASK=0xF0 and OUTSET 0x01 -> `out_port` reflects the new MASK XOR and the new DATA the next cycle. A LEN write mid-pulse does not change the remaining length.
